// File: rtl/arm_mem_pkg.sv
// Shared definitions for the data-memory stage: default SRAM geometry and the
// half-word access state encoding.
package arm_mem_pkg;

    localparam int          DEF_ADDR_W    = 18;
    localparam logic [31:0] DEF_SRAM_BASE = 32'd1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_t;

endpackage

// File: rtl/sram_phase_counter.sv
// Cycle counter for one half-word SRAM phase; wraps at PHASE_CYCLES-1 and
// restarts whenever the owning FSM changes phase.
module sram_phase_counter #(
    parameter int PHASE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic last,
    output logic first_but_last
);

    localparam int            CW       = $clog2(PHASE_CYCLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(PHASE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

    // first_but_last covers every cycle of the phase except the final one
    assign last           = (cnt == LAST_CNT);
    assign first_but_last = (cnt != LAST_CNT);

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller: splits each 32-bit load/store into LOW and HIGH
// half-word phases on an asynchronous 16-bit SRAM and freezes the pipeline meanwhile.
module mem_sram_ctrl
    import arm_mem_pkg::*;
#(
    parameter int          ADDR_W       = DEF_ADDR_W,
    parameter int          PHASE_CYCLES = 2,
    parameter logic [31:0] SRAM_BASE    = DEF_SRAM_BASE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_ce_n
);

    sram_state_t       state_q, state_d;
    logic              is_wr_q;
    logic [ADDR_W-2:0] word_q;
    logic [31:0]       wdata_q;
    logic [31:0]       offset;
    logic              req, phase_en, phase_clr, last, first_but_last;
    logic              unused_bits;

    assign req         = wr_en | rd_en;
    assign offset      = address - SRAM_BASE;
    assign unused_bits = ^{offset[31:ADDR_W+1], offset[1:0]};
    assign phase_en    = (state_q == LOW) || (state_q == HIGH);
    assign phase_clr   = (state_d != state_q);

    sram_phase_counter #(.PHASE_CYCLES(PHASE_CYCLES)) u_phase_counter (
        .clk            (clk),
        .rst            (rst),
        .en             (phase_en),
        .clr            (phase_clr),
        .last           (last),
        .first_but_last (first_but_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req)  state_d = LOW;
            LOW:     if (last) state_d = HIGH;
            HIGH:    if (last) state_d = DONE;
            DONE:              state_d = IDLE;
            default:           state_d = IDLE;
        endcase
    end

    // Request operands are latched on entry so SRAM pins depend only on registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            is_wr_q   <= 1'b0;
            word_q    <= '0;
            wdata_q   <= '0;
            read_data <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                is_wr_q <= wr_en;
                word_q  <= offset[ADDR_W:2];
                wdata_q <= write_data;
            end
            if (!is_wr_q && last && state_q == LOW)  read_data[15:0]  <= sram_dq_in;
            if (!is_wr_q && last && state_q == HIGH) read_data[31:16] <= sram_dq_in;
        end
    end

    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_ce_n   = 1'b1;
        if (phase_en) begin
            sram_ce_n = 1'b0;
            sram_addr = {word_q, (state_q == HIGH)};
            if (is_wr_q) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
                // we_n rises one cycle before the phase ends, keeping address/data stable
                sram_we_n   = ~first_but_last;
            end else begin
                sram_oe_n = 1'b0;
            end
        end
    end

    // ready: 1 = access finished (DONE) or nothing requested; 0 = hold the pipeline frozen
    assign ready = (state_q == DONE) || (state_q == IDLE && !req);

endmodule
